// File: rtl/jump_physics.sv
// Vertical motion engine for one game object: semi-implicit Euler step per frame tick,
// ground/air state machine, damped floor bounce, ceiling clamp and a buffered jump request.
module jump_physics #(
    parameter int W            = 9,
    parameter int VW           = 9,
    parameter int G            = 2,
    parameter int JUMP_V       = 20,
    parameter int VMAX         = 24,
    parameter int CEIL         = 479,
    parameter int BOUNCE_SHIFT = 1,
    parameter int MIN_BOUNCE   = 4,
    parameter int JUMP_BUF     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 jump,
    input  logic [W-1:0]         floor_y,
    output logic [W-1:0]         y,
    output logic signed [VW-1:0] v,
    output logic                 on_ground,
    output logic                 landed,
    output logic                 jump_ack
);
    localparam int CW = $clog2(JUMP_BUF + 1);
    localparam logic signed [VW:0]  G_S      = (VW+1)'(G);
    localparam logic signed [VW:0]  VNEG_MAX = (VW+1)'(-VMAX);
    localparam logic signed [VW:0]  MINB_S   = (VW+1)'(MIN_BOUNCE);
    localparam logic signed [W+1:0] CEIL_S   = (W+2)'(CEIL);
    localparam logic [W:0]          CEIL_U   = (W+1)'(CEIL);
    localparam logic [W:0]          JUMP_U   = (W+1)'(JUMP_V);

    typedef enum logic {GROUND, AIR} state_t;

    state_t               state_q, state_d;
    logic [W-1:0]         y_q, y_d;
    logic signed [VW-1:0] v_q, v_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 landed_q, landed_d;
    logic                 ack_q, ack_d;

    logic                 pend_eff, consume;
    logic signed [VW:0]   vn_raw, vn, b;
    logic signed [W+1:0]  yn, floor_s;
    logic [W:0]           y_jump;

    assign pend_eff = jump | (cnt_q != '0);
    assign consume  = tick & (state_q == GROUND) & pend_eff;

    // Velocity is stepped first and saturated, then the new velocity moves the position.
    assign vn_raw  = {v_q[VW-1], v_q} - G_S;
    assign vn      = (vn_raw < VNEG_MAX) ? VNEG_MAX : vn_raw;
    assign yn      = $signed({2'b00, y_q}) + (W+2)'(vn);
    assign floor_s = $signed({2'b00, floor_y});
    assign b       = (-vn) >>> BOUNCE_SHIFT;
    assign y_jump  = {1'b0, y_q} + JUMP_U;

    always_comb begin
        cnt_d = cnt_q;
        if (consume) begin
            cnt_d = '0;
        end else if (jump) begin
            cnt_d = CW'(JUMP_BUF);
        end else if (tick && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        v_d      = v_q;
        landed_d = 1'b0;
        ack_d    = 1'b0;
        if (tick) begin
            case (state_q)
                GROUND: begin
                    if (pend_eff) begin
                        v_d     = VW'(JUMP_V);
                        y_d     = (y_jump > CEIL_U) ? W'(CEIL) : y_jump[W-1:0];
                        state_d = AIR;
                        ack_d   = 1'b1;
                    end else if (floor_y < y_q) begin
                        state_d = AIR;
                        v_d     = '0;
                    end else begin
                        y_d = floor_y;
                        v_d = '0;
                    end
                end
                AIR: begin
                    if (vn[VW] && yn <= floor_s) begin
                        y_d = floor_y;
                        if (b >= MINB_S) begin
                            v_d = VW'(b);
                        end else begin
                            v_d      = '0;
                            state_d  = GROUND;
                            landed_d = 1'b1;
                        end
                    end else if (yn >= CEIL_S) begin
                        y_d = W'(CEIL);
                        v_d = '0;
                    end else begin
                        y_d = yn[W-1:0];
                        v_d = VW'(vn);
                    end
                end
                default: state_d = GROUND;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= GROUND;
            y_q      <= '0;
            v_q      <= '0;
            cnt_q    <= '0;
            landed_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            v_q      <= v_d;
            cnt_q    <= cnt_d;
            landed_q <= landed_d;
            ack_q    <= ack_d;
        end
    end

    assign y         = y_q;
    assign v         = v_q;
    assign on_ground = (state_q == GROUND);
    assign landed    = landed_q;
    assign jump_ack  = ack_q;
endmodule

// File: tb/tb_jump_physics.sv
// Bench for jump_physics: directed vector table, hand-written flight sequences with
// constant expectations, and random stimulus checked against an integer reference model.
module tb_jump_physics;
    localparam int W = 9, VW = 9, G = 2, JUMP_V = 20, VMAX = 24, CEIL = 479;
    localparam int BS = 1, MINB = 4, JB = 4;

    logic                 clk = 1'b0;
    logic                 rst, tick, jump;
    logic [W-1:0]         floor_y;
    logic [W-1:0]         y;
    logic signed [VW-1:0] v;
    logic                 on_ground, landed, jump_ack;

    jump_physics dut (
        .clk(clk), .rst(rst), .tick(tick), .jump(jump), .floor_y(floor_y),
        .y(y), .v(v), .on_ground(on_ground), .landed(landed), .jump_ack(jump_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: plain integer state following the motion rules directly.
    int m_y, m_v, m_cnt;
    bit m_air, m_landed, m_ack;

    task automatic model(input bit r, input bit t, input bit j, input int fl);
        bit pend;
        int vn, yn, b;
        if (r) begin
            m_y = 0; m_v = 0; m_cnt = 0; m_air = 0; m_landed = 0; m_ack = 0;
            return;
        end
        pend = j || (m_cnt != 0);
        m_landed = 0;
        m_ack = 0;
        if (t && !m_air && pend) m_cnt = 0;
        else if (j) m_cnt = JB;
        else if (t && m_cnt > 0) m_cnt = m_cnt - 1;
        if (!t) return;
        if (!m_air) begin
            if (pend) begin
                m_v = JUMP_V;
                m_y = (m_y + JUMP_V > CEIL) ? CEIL : m_y + JUMP_V;
                m_air = 1;
                m_ack = 1;
            end else if (fl < m_y) begin
                m_air = 1;
                m_v = 0;
            end else begin
                m_y = fl;
                m_v = 0;
            end
        end else begin
            vn = m_v - G;
            if (vn < -VMAX) vn = -VMAX;
            yn = m_y + vn;
            if (vn < 0 && yn <= fl) begin
                m_y = fl;
                b = (-vn) >> BS;
                if (b >= MINB) m_v = b;
                else begin
                    m_v = 0;
                    m_air = 0;
                    m_landed = 1;
                end
            end else if (yn >= CEIL) begin
                m_y = CEIL;
                m_v = 0;
            end else begin
                m_y = yn;
                m_v = vn;
            end
        end
    endtask

    task automatic step(input bit r, input bit t, input bit j, input int fl);
        rst = r; tick = t; jump = j; floor_y = W'(fl);
        model(r, t, j, fl);
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n, input int fl);
        for (int k = 0; k < n; k++) step(0, 1, 0, fl);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input int ey, input int ev,
                             input bit eg, input bit el, input bit ea);
        $display("%s: y=%0d v=%0d on_ground=%0b landed=%0b jump_ack=%0b",
                 name, y, v, on_ground, landed, jump_ack);
        check({name, ".y"}, int'(y), ey);
        check({name, ".v"}, int'(v), ev);
        check({name, ".on_ground"}, int'(on_ground), int'(eg));
        check({name, ".landed"}, int'(landed), int'(el));
        check({name, ".jump_ack"}, int'(jump_ack), int'(ea));
    endtask

    typedef struct {
        bit r, t, j;
        int fl;
        int ey, ev;
        bit eg, el, ea;
    } vec_t;

    vec_t tbl[9];
    int   fl_r;
    bit   r_r, t_r, j_r;

    initial begin
        rst = 1'b1; tick = 1'b0; jump = 1'b0; floor_y = '0;
        // r t j floor  y   v  gnd lnd ack
        tbl[0] = '{1, 0, 0, 100,   0,  0, 1, 0, 0};
        tbl[1] = '{0, 1, 0, 100, 100,  0, 1, 0, 0};
        tbl[2] = '{0, 0, 0, 100, 100,  0, 1, 0, 0};
        tbl[3] = '{0, 1, 1, 100, 120, 20, 0, 0, 1};
        tbl[4] = '{0, 0, 0, 100, 120, 20, 0, 0, 0};
        tbl[5] = '{0, 1, 0, 100, 138, 18, 0, 0, 0};
        tbl[6] = '{0, 1, 0, 100, 154, 16, 0, 0, 0};
        tbl[7] = '{0, 0, 1, 100, 154, 16, 0, 0, 0};
        tbl[8] = '{1, 1, 1, 100,   0,  0, 1, 0, 0};
        for (int i = 0; i < 9; i++) begin
            step(tbl[i].r, tbl[i].t, tbl[i].j, tbl[i].fl);
            check_all($sformatf("vec%0d", i), tbl[i].ey, tbl[i].ev,
                      tbl[i].eg, tbl[i].el, tbl[i].ea);
        end

        // Bounce chain from a launch at floor 100.
        step(1, 0, 0, 100);
        step(0, 1, 0, 100);
        step(0, 1, 1, 100); check_all("bnc_launch", 120, 20, 0, 0, 1);
        step(0, 1, 0, 100); check_all("bnc_t1", 138, 18, 0, 0, 0);
        ticks(19, 100);     check_all("bnc_impact20", 100, 10, 0, 0, 0);
        ticks(9, 100);      check_all("bnc_impact8", 100, 4, 0, 0, 0);
        step(0, 1, 0, 100); check_all("bnc_up1", 102, 2, 0, 0, 0);
        step(0, 1, 0, 100); check_all("bnc_apex", 102, 0, 0, 0, 0);
        step(0, 1, 0, 100); check_all("bnc_land", 100, 0, 1, 1, 0);
        step(0, 0, 0, 100); check_all("bnc_after", 100, 0, 1, 0, 0);

        // Terminal velocity after walking off a high floor.
        step(1, 0, 0, 400);
        step(0, 1, 0, 400); check_all("term_settle", 400, 0, 1, 0, 0);
        step(0, 1, 0, 0);   check_all("term_ledge", 400, 0, 0, 0, 0);
        ticks(12, 0);       check_all("term_12", 244, -24, 0, 0, 0);
        step(0, 1, 0, 0);   check_all("term_13", 220, -24, 0, 0, 0);
        step(0, 1, 0, 0);   check_all("term_14", 196, -24, 0, 0, 0);

        // Ceiling clamp on launch and head bump.
        step(1, 0, 0, 470);
        step(0, 1, 0, 470); check_all("ceil_settle", 470, 0, 1, 0, 0);
        step(0, 1, 1, 470); check_all("ceil_launch", 479, 20, 0, 0, 1);
        step(0, 1, 0, 470); check_all("ceil_bump", 479, 0, 0, 0, 0);

        // Jump pulse three ticks before landing launches on the next tick.
        step(1, 0, 0, 100);
        step(0, 1, 0, 100);
        step(0, 1, 0, 90);  check_all("buf3_ledge", 100, 0, 0, 0, 0);
        step(0, 0, 1, 90);  check_all("buf3_req", 100, 0, 0, 0, 0);
        step(0, 1, 0, 90);  check_all("buf3_t1", 98, -2, 0, 0, 0);
        step(0, 1, 0, 90);  check_all("buf3_t2", 94, -4, 0, 0, 0);
        step(0, 1, 0, 90);  check_all("buf3_land", 90, 0, 1, 1, 0);
        step(0, 1, 0, 90);  check_all("buf3_launch", 110, 20, 0, 0, 1);

        // Jump pulse five ticks before landing expires.
        step(1, 0, 0, 100);
        step(0, 1, 0, 100);
        step(0, 1, 0, 84);
        ticks(2, 84);       check_all("buf5_t2", 94, -4, 0, 0, 0);
        step(0, 0, 1, 84);
        step(0, 1, 0, 84);  check_all("buf5_t3", 88, -6, 0, 0, 0);
        step(0, 1, 0, 84);  check_all("buf5_bounce", 84, 4, 0, 0, 0);
        ticks(2, 84);       check_all("buf5_apex", 86, 0, 0, 0, 0);
        step(0, 1, 0, 84);  check_all("buf5_land", 84, 0, 1, 1, 0);
        step(0, 1, 0, 84);  check_all("buf5_nolaunch", 84, 0, 1, 0, 0);

        // Reset mid-flight, and reset together with tick and jump.
        step(0, 1, 1, 84);
        step(0, 1, 0, 84);
        step(1, 0, 0, 84);  check_all("rst_air", 0, 0, 1, 0, 0);
        step(0, 1, 0, 100);
        step(1, 1, 1, 100); check_all("rst_same", 0, 0, 1, 0, 0);
        step(0, 1, 0, 100); check_all("rst_nobuf", 100, 0, 1, 0, 0);

        // Random traffic against the reference model.
        fl_r = 100;
        step(1, 0, 0, fl_r);
        for (int i = 0; i < 600; i++) begin
            r_r = ($urandom_range(0, 149) == 0);
            t_r = ($urandom_range(0, 2) != 0);
            j_r = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 29) == 0) fl_r = $urandom_range(0, CEIL);
            step(r_r, t_r, j_r, fl_r);
            check_all($sformatf("rnd%0d", i), m_y, m_v, !m_air, m_landed, m_ack);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
